// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB register completer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Transfer state of the completer.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Number of index bits needed to address a bank of n registers.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_bank
// Description : Register storage with one write port and a combinational
//               read mux. Entry 0 is a read-only ID constant.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS = 8,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we_i,
    input  logic [idx_width(NUM_REGS)-1:0]   widx_i,
    input  logic [APB_DATA_W-1:0]            wdata_i,
    input  logic [idx_width(NUM_REGS)-1:0]   ridx_i,
    output logic [APB_DATA_W-1:0]            rdata_o
);

    localparam int IDX_W = idx_width(NUM_REGS);

    logic [APB_DATA_W-1:0] w_regs [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_id
                assign w_regs[gi] = ID_VALUE;
            end else begin : g_reg
                logic [APB_DATA_W-1:0] data_q;
                // Storage for one writable register, cleared by reset.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        data_q <= '0;
                    end else if (we_i && (widx_i == IDX_W'(gi))) begin
                        data_q <= wdata_i;
                    end
                end
                assign w_regs[gi] = data_q;
            end
        end
    endgenerate

    assign rdata_o = w_regs[ridx_i];

endmodule
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_slave
// Description : APB completer serving a bank of 32-bit registers in a fixed
//               address window. Register 0 holds a read-only ID. Misses and
//               writes to register 0 answer with pslverr.
//               Optional macro APB_REG_SLAVE_WAIT_EN enables insertion of
//               WAIT_CYCLES wait states in every access phase.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'hDEAD_CAE0,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic [APB_ADDR_W-1:0]          paddr_i,
    input  logic                           pwrite_i,
    input  logic [APB_DATA_W-1:0]          pwdata_i,
    output logic                           pready_o,
    output logic [APB_DATA_W-1:0]          prdata_o,
    output logic                           pslverr_o,
    output logic                           wr_pulse_o,
    output logic [idx_width(NUM_REGS)-1:0] wr_idx_o
);

    localparam int IDX_W   = idx_width(NUM_REGS);
    localparam int DEC_LSB = IDX_W + 2;

    // Transfer context latched in the setup phase.
    apb_state_e        state_q;
    logic              write_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_pulse_q;
    logic [IDX_W-1:0]  wr_idx_q;

    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_cnt_zero;
    logic                  w_ready;
    logic                  w_we;
    logic [APB_DATA_W-1:0] w_rdata;

    // Window decode: byte offset bits [1:0] are ignored.
    assign w_hit = (paddr_i[APB_ADDR_W-1:DEC_LSB] == BASE_ADDR[APB_ADDR_W-1:DEC_LSB]);
    assign w_idx = paddr_i[DEC_LSB-1:2];
    assign w_err = !w_hit || (pwrite_i && (w_idx == '0));

`ifdef APB_REG_SLAVE_WAIT_EN
    logic [3:0] cnt_q;
    assign w_cnt_zero = (cnt_q == 4'd0);
`else
    assign w_cnt_zero = 1'b1;
`endif

    // pready depends only on registered state, never on itself.
    assign w_ready = (state_q == ACCESS) && w_cnt_zero;
    assign w_we    = w_ready && psel_i && penable_i && write_q && !err_q;

    // Transfer FSM: setup latching, wait countdown, completion and abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
`ifdef APB_REG_SLAVE_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        write_q <= pwrite_i;
                        err_q   <= w_err;
                        idx_q   <= w_idx;
`ifdef APB_REG_SLAVE_WAIT_EN
                        cnt_q   <= 4'(WAIT_CYCLES);
`endif
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state_q <= IDLE;
                    end else if (w_ready && penable_i) begin
                        state_q <= IDLE;
                    end
`ifdef APB_REG_SLAVE_WAIT_EN
                    if (!w_cnt_zero) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-commit notification: pulse and sticky index one cycle after commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            wr_pulse_q <= w_we;
            if (w_we) begin
                wr_idx_q <= idx_q;
            end
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_we),
        .widx_i  (idx_q),
        .wdata_i (pwdata_i),
        .ridx_i  (idx_q),
        .rdata_o (w_rdata)
    );

    assign pready_o   = w_ready;
    assign pslverr_o  = w_ready && err_q;
    assign prdata_o   = (w_ready && !err_q && !write_q) ? w_rdata : '0;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_idx_o   = wr_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_reg_slave
// Description : Scoreboard bench for apb_reg_slave with a reference model of
//               the register window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

    localparam logic [31:0] BASE   = 32'hDEAD_CAE0;
    localparam int          NREGS  = 8;
    localparam int          WAITS  = 3;
    localparam logic [31:0] IDV    = 32'hA5B0_0001;
`ifdef APB_REG_SLAVE_WAIT_EN
    localparam int          EXP_W  = WAITS;
`else
    localparam int          EXP_W  = 0;
`endif

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] data;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pready, pslverr, wr_pulse;
    logic [31:0] prdata;
    logic [2:0]  wr_idx;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [31:0] model [NREGS];
    int          acc_cnt = 0;
    bit          pend_pulse = 1'b0;
    int          pend_idx = 0;
    int          exp_wr_idx = 0;

    apb_reg_slave #(
        .BASE_ADDR   (BASE),
        .NUM_REGS    (NREGS),
        .WAIT_CYCLES (WAITS),
        .ID_VALUE    (IDV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .psel_i     (psel),
        .penable_i  (penable),
        .paddr_i    (paddr),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .wr_pulse_o (wr_pulse),
        .wr_idx_o   (wr_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        model[0] = IDV;
        for (int i = 1; i < NREGS; i++) model[i] = '0;
    endfunction

    // Reference model: window [BASE, BASE+4*NREGS); register 0 is read-only.
    function automatic exp_t predict(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   hit;
        int   idx;
        hit = (a >= BASE) && ((a - BASE) < 32'(NREGS * 4));
        idx = hit ? int'((a - BASE) / 4) : 0;
        e.wr  = wr;
        e.idx = idx;
        e.err = !hit || (wr && idx == 0);
        e.data = (!wr && !e.err) ? model[idx] : 32'h0;
        if (wr && !e.err) model[idx] = d;
        return e;
    endfunction

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        int n;
        sbq.push_back(predict(wr, a, d));
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        n = 0;
        rd = '0;
        forever begin
            @(negedge clk);
            if (pready) begin rd = prdata; break; end
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL timeout: pready never rose for addr %h", a);
                break;
            end
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    // Monitor: compares completions against the scoreboard and tracks pulses.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            acc_cnt = 0;
            pend_pulse = 1'b0;
            exp_wr_idx = 0;
        end else begin
            chk("wr_pulse", {31'b0, wr_pulse}, {31'b0, pend_pulse});
            if (pend_pulse) exp_wr_idx = pend_idx;
            chk("wr_idx", {29'b0, wr_idx}, 32'(exp_wr_idx));
            pend_pulse = 1'b0;
            if (psel && penable) begin
                acc_cnt++;
                if (pready) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboard: completion with empty queue");
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("latency", 32'(acc_cnt - 1), 32'(EXP_W));
                        chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
                        if (!e.wr || e.err) chk("prdata", prdata, e.data);
                        if (e.wr && !e.err) begin
                            pend_pulse = 1'b1;
                            pend_idx = e.idx;
                        end
                    end
                    acc_cnt = 0;
                end
            end else begin
                acc_cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", {31'b0, pready}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_wr_pulse", {31'b0, wr_pulse}, 32'h0);
        chk("rst_wr_idx", {29'b0, wr_idx}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ID read and basic write/readback.
        xfer(1'b0, 32'hDEAD_CAE0, 32'h0, rd);
        xfer(1'b1, 32'hDEAD_CAFE, 32'h0000_0010, rd);
        xfer(1'b0, 32'hDEAD_CAFC, 32'h0, rd);

        // Master read-increment-write loop on idx 7 starting from 0.
        xfer(1'b1, 32'hDEAD_CAFE, 32'h0, rd);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'hDEAD_CAFE, 32'h0, rd);
            xfer(1'b1, 32'hDEAD_CAFE, rd + 32'd1, rd);
        end
        xfer(1'b0, 32'hDEAD_CAFE, 32'h0, rd);
        chk("incr_final", rd, 32'd3);

        // Error responses.
        xfer(1'b1, 32'hDEAD_CAE0, 32'h1234_5678, rd);
        xfer(1'b0, 32'h0000_1000, 32'h0, rd);
        xfer(1'b0, 32'hDEAD_CAE0, 32'h0, rd);

        // Abort: psel dropped after setup while writing 0x55 to idx 3.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hDEAD_CAEC; pwdata = 32'h55;
        @(posedge clk); #1 psel = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'hDEAD_CAEC, 32'h0, rd);

        // Reset asserted mid-write of 0x55 to idx 3.
        xfer(1'b1, 32'hDEAD_CAE8, 32'hCAFE_0002, rd);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hDEAD_CAEC; pwdata = 32'h55;
        @(posedge clk); #1 penable = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_pready", {31'b0, pready}, 32'h0);
        chk("midrst_wr_idx", {29'b0, wr_idx}, 32'h0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 32'hDEAD_CAEC, 32'h0, rd);
        xfer(1'b0, 32'hDEAD_CAE8, 32'h0, rd);

        // Randomized traffic, inside and outside the window.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0)
                a = $urandom();
            else
                a = BASE + 32'($urandom_range(0, NREGS - 1) * 4) + 32'($urandom_range(0, 3));
            xfer(1'b1 & $urandom_range(0, 1), a, $urandom(), rd);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
